// File: rtl/trace_capture_pkg.sv
// Shared types and constants for the retired-instruction trace buffer.
package trace_capture_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] inst;
        logic [31:0] data;
    } trace_rec_t;

    localparam int          TRACE_DEPTH_DEFAULT = 8;
    localparam logic [15:0] DROP_CNT_MAX        = 16'hFFFF;

    // The drop counter holds at its maximum instead of wrapping back to zero.
    function automatic logic [15:0] drop_cnt_inc(input logic [15:0] v);
        return (v == DROP_CNT_MAX) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/trace_capture_if.sv
// Bundle of trace input, capture control and dequeue/status signals.
interface trace_capture_if
    import trace_capture_pkg::*;
#(
    parameter int DEPTH = TRACE_DEPTH_DEFAULT
) ();
    logic                     trace_val;
    logic [31:0]              trace_addr;
    logic [31:0]              trace_inst;
    logic [31:0]              trace_data;
    logic                     en;
    logic                     clr;
    logic                     deq_val;
    logic                     deq_rdy;
    logic [31:0]              deq_addr;
    logic [31:0]              deq_inst;
    logic [31:0]              deq_data;
    logic [$clog2(DEPTH):0]   count;
    logic                     full;
    logic                     ovf;
    logic [15:0]              drop_cnt;

    modport master (
        output trace_val, trace_addr, trace_inst, trace_data, en, clr, deq_rdy,
        input  deq_val, deq_addr, deq_inst, deq_data, count, full, ovf, drop_cnt
    );

    modport slave (
        input  trace_val, trace_addr, trace_inst, trace_data, en, clr, deq_rdy,
        output deq_val, deq_addr, deq_inst, deq_data, count, full, ovf, drop_cnt
    );
endinterface

// File: rtl/trace_capture_mem.sv
// Record storage: synchronous write, combinational read, no reset on the array.
module trace_capture_mem
    import trace_capture_pkg::*;
#(
    parameter int DEPTH = TRACE_DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  trace_rec_t               wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output trace_rec_t               rdata_o
);
    trace_rec_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/trace_capture.sv
// Trace capture FIFO: buffers retired-instruction records, counts drops on overflow.
module trace_capture
    import trace_capture_pkg::*;
#(
    parameter int DEPTH = TRACE_DEPTH_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    trace_capture_if.slave tc
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic [15:0]      drop_cnt_q, drop_cnt_d;

    logic       deq_val;
    logic       full;
    logic       enq_try;
    logic       deq_fire;
    logic       enq_ok;
    logic       enq_drop;
    logic       mem_we;
    trace_rec_t wr_rec;
    trace_rec_t rd_rec;

    assign deq_val  = (count_q != '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    assign enq_try  = tc.en & tc.trace_val;
    assign deq_fire = deq_val & tc.deq_rdy;
    // A full buffer still accepts when the head leaves on the same edge.
    assign enq_ok   = enq_try & (~full | deq_fire);
    assign enq_drop = enq_try & full & ~deq_fire;
    assign mem_we   = enq_ok & ~tc.clr;

    assign wr_rec = '{addr: tc.trace_addr, inst: tc.trace_inst, data: tc.trace_data};

    trace_capture_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_rec),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_rec)
    );

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        drop_cnt_d = drop_cnt_q;
        if (tc.clr) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            ovf_d      = 1'b0;
            drop_cnt_d = '0;
        end else begin
            if (enq_ok) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (deq_fire) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CNT_W'(enq_ok) - CNT_W'(deq_fire);
            if (enq_drop) begin
                ovf_d      = 1'b1;
                drop_cnt_d = drop_cnt_inc(drop_cnt_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Head fields are forced to zero whenever nothing is buffered.
    assign tc.deq_val  = deq_val;
    assign tc.deq_addr = deq_val ? rd_rec.addr : 32'd0;
    assign tc.deq_inst = deq_val ? rd_rec.inst : 32'd0;
    assign tc.deq_data = deq_val ? rd_rec.data : 32'd0;
    assign tc.count    = count_q;
    assign tc.full     = full;
    assign tc.ovf      = ovf_q;
    assign tc.drop_cnt = drop_cnt_q;
endmodule

// File: tb/tb_trace_capture.sv
// Scoreboard bench for trace_capture: a reference queue predicts every head record and status.
module tb_trace_capture;
    import trace_capture_pkg::*;

    localparam int DEPTH = 8;

    logic clk;
    logic rst;

    trace_capture_if #(.DEPTH(DEPTH)) tc_if ();

    trace_capture #(
        .DEPTH (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .tc  (tc_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    trace_rec_t  m_q[$];
    bit          m_ovf;
    int          m_drop;
    int          n_chk;
    int          n_pass;
    int          n_drained;
    logic [31:0] last_addr;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic check_state();
        chk("count", 64'(tc_if.count), 64'(m_q.size()));
        chk("full", 64'(tc_if.full), 64'(m_q.size() == DEPTH));
        chk("ovf", 64'(tc_if.ovf), 64'(m_ovf));
        chk("drop_cnt", 64'(tc_if.drop_cnt), 64'(m_drop));
        chk("deq_val", 64'(tc_if.deq_val), 64'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            chk("head_addr", 64'(tc_if.deq_addr), 64'(m_q[0].addr));
            chk("head_inst", 64'(tc_if.deq_inst), 64'(m_q[0].inst));
            chk("head_data", 64'(tc_if.deq_data), 64'(m_q[0].data));
        end else begin
            chk("idle_fields", {tc_if.deq_addr, tc_if.deq_inst ^ tc_if.deq_data}, 64'd0);
        end
    endtask

    task automatic drive(input bit v, input logic [31:0] a, input logic [31:0] i,
                         input logic [31:0] d);
        tc_if.trace_val  = v;
        tc_if.trace_addr = a;
        tc_if.trace_inst = i;
        tc_if.trace_data = d;
    endtask

    // Predict the edge from the inputs now held, then advance one clock and compare.
    task automatic cycle();
        bit         deq_fire;
        bit         enq_try;
        bit         was_full;
        trace_rec_t r;
        deq_fire = (m_q.size() != 0) && tc_if.deq_rdy;
        enq_try  = tc_if.en && tc_if.trace_val;
        was_full = (m_q.size() == DEPTH);
        if (tc_if.clr) begin
            m_q.delete();
            m_ovf  = 1'b0;
            m_drop = 0;
        end else begin
            if (deq_fire) begin
                r = m_q.pop_front();
                chk("drain_addr", 64'(tc_if.deq_addr), 64'(r.addr));
                chk("drain_inst", 64'(tc_if.deq_inst), 64'(r.inst));
                chk("drain_data", 64'(tc_if.deq_data), 64'(r.data));
                last_addr = r.addr;
                n_drained++;
            end
            if (enq_try) begin
                if (!was_full || deq_fire) begin
                    m_q.push_back('{addr: tc_if.trace_addr, inst: tc_if.trace_inst,
                                    data: tc_if.trace_data});
                end else begin
                    m_ovf = 1'b1;
                    if (m_drop < 65535) m_drop++;
                end
            end
        end
        @(posedge clk);
        #1;
        check_state();
    endtask

    initial begin
        n_chk     = 0;
        n_pass    = 0;
        n_drained = 0;
        m_ovf     = 1'b0;
        m_drop    = 0;
        last_addr = '0;
        rst          = 1'b0;
        tc_if.en     = 1'b0;
        tc_if.clr    = 1'b0;
        tc_if.deq_rdy = 1'b0;
        drive(1'b0, '0, '0, '0);

        // Reset state, checked before any clock edge.
        #3;
        check_state();
        @(posedge clk);
        #1;
        rst = 1'b1;
        check_state();

        // Single jal retire.
        tc_if.en = 1'b1;
        drive(1'b1, 32'h000, 32'h008000EF, 32'h004);
        cycle();
        chk("jal_count", 64'(tc_if.count), 64'd1);
        chk("jal_addr", 64'(tc_if.deq_addr), 64'h000);
        chk("jal_data", 64'(tc_if.deq_data), 64'h004);
        drive(1'b0, '0, '0, '0);
        tc_if.deq_rdy = 1'b1;
        cycle();

        // Retirement order, then drain to empty.
        tc_if.deq_rdy = 1'b0;
        drive(1'b1, 32'h000, 32'h11, 32'h21); cycle();
        drive(1'b1, 32'h008, 32'h12, 32'h22); cycle();
        drive(1'b1, 32'h00C, 32'h13, 32'h23); cycle();
        drive(1'b0, '0, '0, '0);
        tc_if.deq_rdy = 1'b1;
        n_drained = 0;
        for (int k = 0; k < 4; k++) cycle();
        chk("order_drained", 64'(n_drained), 64'd3);
        chk("order_last", 64'(last_addr), 64'h00C);

        // Overflow: ten retires into eight slots.
        tc_if.deq_rdy = 1'b0;
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 32'h200 + 32'(4 * k), 32'hA000 + 32'(k), 32'hB000 + 32'(k));
            cycle();
        end
        chk("ovf_full", 64'(tc_if.full), 64'd1);
        chk("ovf_drop", 64'(tc_if.drop_cnt), 64'd2);

        // Full with simultaneous dequeue accepts the new record.
        tc_if.deq_rdy = 1'b1;
        drive(1'b1, 32'h100, 32'hC0DE, 32'hD00D);
        cycle();
        chk("fullsim_count", 64'(tc_if.count), 64'd8);
        chk("fullsim_ovf", 64'(tc_if.ovf), 64'd1);
        drive(1'b0, '0, '0, '0);
        n_drained = 0;
        for (int k = 0; k < 8; k++) cycle();
        chk("fullsim_last", 64'(last_addr), 64'h100);

        // Enqueue and dequeue attempted together while empty.
        drive(1'b1, 32'h300, 32'h1, 32'h2);
        cycle();
        chk("empty_sim_count", 64'(tc_if.count), 64'd1);

        // Clear overrides a same-cycle retire.
        tc_if.deq_rdy = 1'b0;
        for (int k = 0; k < 9; k++) begin
            drive(1'b1, 32'h400 + 32'(k), 32'h0, 32'h0);
            cycle();
        end
        tc_if.clr = 1'b1;
        drive(1'b1, 32'h500, 32'h5, 32'h6);
        cycle();
        tc_if.clr = 1'b0;
        chk("clr_drop", 64'(tc_if.drop_cnt), 64'd0);

        // Capture disabled: retires are ignored, dequeue still runs.
        tc_if.en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'h600 + 32'(k), 32'h0, 32'h0);
            cycle();
        end
        chk("en0_count", 64'(tc_if.count), 64'd0);
        tc_if.en = 1'b1;
        drive(1'b1, 32'h700, 32'h7, 32'h8); cycle();
        drive(1'b1, 32'h704, 32'h9, 32'hA); cycle();
        tc_if.en = 1'b0;
        tc_if.deq_rdy = 1'b1;
        cycle();
        chk("en0_deq_count", 64'(tc_if.count), 64'd1);
        cycle();

        // Asynchronous reset with five records buffered.
        tc_if.en = 1'b1;
        tc_if.deq_rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 32'h800 + 32'(4 * k), 32'h0, 32'h0);
            cycle();
        end
        drive(1'b0, '0, '0, '0);
        rst = 1'b0;
        #2;
        m_q.delete();
        m_ovf  = 1'b0;
        m_drop = 0;
        chk("arst_count", 64'(tc_if.count), 64'd0);
        chk("arst_deq_val", 64'(tc_if.deq_val), 64'd0);
        chk("arst_deq_addr", 64'(tc_if.deq_addr), 64'd0);
        check_state();
        rst = 1'b1;
        #1;
        drive(1'b1, 32'h900, 32'h90, 32'h91);
        cycle();
        chk("post_arst_addr", 64'(tc_if.deq_addr), 64'h900);

        // Mixed random traffic exercises pointer wrap and every edge case together.
        for (int k = 0; k < 300; k++) begin
            tc_if.en      = ($urandom_range(0, 7) != 0);
            tc_if.deq_rdy = ($urandom_range(0, 2) == 0);
            tc_if.clr     = ($urandom_range(0, 49) == 0);
            drive($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
